// File: rtl/csr_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_intr_ctrl_if
// Control-unit side bundle for the machine-mode CSR file / interrupt
// controller: csrrw access, trap/mret handshake, and the trap/return
// targets fed back to the PC mux.
// ---------------------------------------------------------------------------
interface csr_intr_ctrl_if;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] csr_rd;
    logic        int_taken;
    logic        mret_exec;
    logic [31:0] pc;
    logic        int_pending;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie_bit;

    // Control unit / decoder side
    modport master (
        output csr_we,
        output csr_addr,
        output csr_wd,
        output int_taken,
        output mret_exec,
        output pc,
        input  csr_rd,
        input  int_pending,
        input  mtvec,
        input  mepc,
        input  mie_bit
    );

    // CSR file / interrupt controller side
    modport slave (
        input  csr_we,
        input  csr_addr,
        input  csr_wd,
        input  int_taken,
        input  mret_exec,
        input  pc,
        output csr_rd,
        output int_pending,
        output mtvec,
        output mepc,
        output mie_bit
    );
endinterface

// File: rtl/csr_intr_ctrl.sv
// ---------------------------------------------------------------------------
// csr_intr_ctrl
// Machine-mode CSR file and interrupt controller for the OTTER core.
// Synchronizes asynchronous interrupt lines, latches rising edges as pending,
// arbitrates among enabled pending sources and raises int_pending to the
// control unit. Holds mstatus(MIE/MPIE), mie, mtvec, mepc, mcause and a
// read-only mip view.
//
// Optional build macro: INTR_RR_EN
//   defined   -> round-robin arbitration with a last-winner pointer
//   undefined -> fixed priority, lowest source index wins
// ---------------------------------------------------------------------------
module csr_intr_ctrl #(
    parameter int          NUM_SRC     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] intr_src,
    csr_intr_ctrl_if.slave     bus
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    // Synchronizer and edge-detect pipeline
    logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];
    logic [NUM_SRC-1:0] edge_r;
    logic [NUM_SRC-1:0] rise_r;

    // Interrupt state
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] pending_nx_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] cand_s;
    logic [SEL_W-1:0]   sel_s;
    logic               found_s;
    state_t             state_r;
    state_t             state_nx_s;

    // CSR registers
    logic [NUM_SRC-1:0] mie_en_r;
    logic [31:0]        mtvec_r;
    logic [31:0]        mepc_r;
    logic [31:0]        mcause_r;
    logic               mstatus_mie_r;
    logic               mstatus_mpie_r;
    logic [31:0]        csr_rd_s;

    // Qualified events
    logic int_pending_s;
    logic trap_take_s;
    logic mret_s;
    logic wr_mstatus_s;
    logic wr_mie_s;
    logic wr_mtvec_s;
    logic wr_mepc_s;
    logic wr_mcause_s;

    // The low PC bits are always dropped when saving mepc.
    logic unused_pc_lsb_s;
    assign unused_pc_lsb_s = ^bus.pc[1:0];

`ifdef INTR_RR_EN
    logic [SEL_W-1:0] last_r;
    int               rr_idx_s;
`endif

    // Shift interrupt lines through the synchronizer, then register the rising edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
            edge_r <= '0;
            rise_r <= '0;
        end else begin
            sync_r[0] <= intr_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            edge_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~edge_r;
        end
    end

    // Pick the winning source among enabled pending requests
    always_comb begin
        cand_s  = pending_r & mie_en_r;
        sel_s   = {SEL_W{1'b0}};
        found_s = 1'b0;
`ifdef INTR_RR_EN
        rr_idx_s = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx_s = (int'(last_r) + 1 + k) % NUM_SRC;
            if (!found_s && cand_s[rr_idx_s]) begin
                sel_s   = SEL_W'(rr_idx_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
`else
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found_s && cand_s[k]) begin
                sel_s   = SEL_W'(k);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
`endif
    end

    // Interrupt request, trap acceptance and CSR write decode
    always_comb begin
        int_pending_s = (state_r == ST_RUN) & mstatus_mie_r & found_s;
        trap_take_s   = bus.int_taken & int_pending_s;
        mret_s        = bus.mret_exec & ~trap_take_s;
        wr_mstatus_s  = bus.csr_we & (bus.csr_addr == ADDR_MSTATUS);
        wr_mie_s      = bus.csr_we & (bus.csr_addr == ADDR_MIE);
        wr_mtvec_s    = bus.csr_we & (bus.csr_addr == ADDR_MTVEC);
        wr_mepc_s     = bus.csr_we & (bus.csr_addr == ADDR_MEPC);
        wr_mcause_s   = bus.csr_we & (bus.csr_addr == ADDR_MCAUSE);
    end

    // Clear the accepted source; a same-cycle new edge keeps it pending
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            clr_s[k] = trap_take_s & (sel_s == SEL_W'(k));
        end
        pending_nx_s = (pending_r & ~clr_s) | rise_r;
    end

    // Pending request register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nx_s;
        end
    end

    // RUN/TRAP next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (trap_take_s) begin
                    state_nx_s = ST_TRAP;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (mret_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_TRAP;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // RUN/TRAP state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // mstatus: trap entry beats mret, which beats a software write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
        end else if (trap_take_s) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (mret_s) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (wr_mstatus_s) begin
            mstatus_mie_r  <= bus.csr_wd[3];
            mstatus_mpie_r <= bus.csr_wd[7];
        end
    end

    // mepc and mcause: trap entry beats a software write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mepc_r   <= 32'h0000_0000;
            mcause_r <= 32'h0000_0000;
        end else if (trap_take_s) begin
            mepc_r   <= {bus.pc[31:2], 2'b00};
            mcause_r <= 32'h8000_0000 | (32'd16 + 32'(sel_s));
        end else begin
            if (wr_mepc_s) begin
                mepc_r <= {bus.csr_wd[31:2], 2'b00};
            end
            if (wr_mcause_s) begin
                mcause_r <= bus.csr_wd;
            end
        end
    end

    // Software-only CSRs: trap vector and source enables
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mtvec_r  <= MTVEC_RST;
            mie_en_r <= '0;
        end else begin
            if (wr_mtvec_s) begin
                mtvec_r <= {bus.csr_wd[31:2], 2'b00};
            end
            if (wr_mie_s) begin
                mie_en_r <= bus.csr_wd[16 +: NUM_SRC];
            end
        end
    end

`ifdef INTR_RR_EN
    // Remember the last accepted source so the next search starts after it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_r <= {SEL_W{1'b0}};
        end else if (trap_take_s) begin
            last_r <= sel_s;
        end
    end
`endif

    // CSR read mux, returns the value before any same-cycle write
    always_comb begin
        csr_rd_s = 32'h0000_0000;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                csr_rd_s[3] = mstatus_mie_r;
                csr_rd_s[7] = mstatus_mpie_r;
            end
            ADDR_MIE: begin
                csr_rd_s[16 +: NUM_SRC] = mie_en_r;
            end
            ADDR_MTVEC: begin
                csr_rd_s = mtvec_r;
            end
            ADDR_MEPC: begin
                csr_rd_s = mepc_r;
            end
            ADDR_MCAUSE: begin
                csr_rd_s = mcause_r;
            end
            ADDR_MIP: begin
                csr_rd_s[16 +: NUM_SRC] = pending_r;
            end
            default: begin
                csr_rd_s = 32'h0000_0000;
            end
        endcase
    end

    assign bus.csr_rd      = csr_rd_s;
    assign bus.int_pending = int_pending_s;
    assign bus.mtvec       = mtvec_r;
    assign bus.mepc        = mepc_r;
    assign bus.mie_bit     = mstatus_mie_r;

endmodule

// File: tb/tb_csr_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_intr_ctrl
// Directed self-checking bench for csr_intr_ctrl (NUM_SRC=4, SYNC_STAGES=2).
// Inputs change on the falling edge; outputs are checked away from the
// rising edge.
// ---------------------------------------------------------------------------
module tb_csr_intr_ctrl;

    logic       CLK;
    logic       RST_N;
    logic [3:0] intr_src;
    int         n_pass;
    int         n_total;

    csr_intr_ctrl_if bus();

    csr_intr_ctrl #(
        .NUM_SRC     (4),
        .SYNC_STAGES (2),
        .MTVEC_RST   (32'h0000_0000)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .intr_src (intr_src),
        .bus      (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // one full clock, ending on a falling edge
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // read a CSR and compare; consumes one clock
    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_addr = a;
        #1;
        chk(tag, bus.csr_rd, exp);
        @(negedge CLK);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_we   = 1'b1;
        bus.csr_addr = a;
        bus.csr_wd   = d;
        tick();
        bus.csr_we   = 1'b0;
    endtask

    task automatic take(input logic [31:0] p, input logic with_mret);
        bus.int_taken = 1'b1;
        bus.mret_exec = with_mret;
        bus.pc        = p;
        tick();
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
    endtask

    task automatic mret();
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;
    endtask

    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [31:0] exp_r3;

    initial begin
        n_pass        = 0;
        n_total       = 0;
        RST_N         = 1'b0;
        intr_src      = 4'h0;
        bus.csr_we    = 1'b0;
        bus.csr_addr  = 12'h000;
        bus.csr_wd    = 32'h0000_0000;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        bus.pc        = 32'h0000_0000;
`ifdef INTR_RR_EN
        exp_r1 = 32'h8000_0012;
        exp_r2 = 32'h8000_0010;
        exp_r3 = 32'h8000_0012;
`else
        exp_r1 = 32'h8000_0010;
        exp_r2 = 32'h8000_0012;
        exp_r3 = 32'h8000_0010;
`endif

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_int_pending", {31'd0, bus.int_pending}, 32'd0);
        chk("rst_mie_bit", {31'd0, bus.mie_bit}, 32'd0);
        chk("rst_mtvec", bus.mtvec, 32'h0000_0000);
        chk("rst_mepc", bus.mepc, 32'h0000_0000);
        RST_N = 1'b1;
        tick();
        rd_chk("rd_mstatus", 12'h300, 32'h0000_0000);
        rd_chk("rd_mie", 12'h304, 32'h0000_0000);
        rd_chk("rd_mtvec", 12'h305, 32'h0000_0000);
        rd_chk("rd_mepc", 12'h341, 32'h0000_0000);
        rd_chk("rd_mcause", 12'h342, 32'h0000_0000);
        rd_chk("rd_mip", 12'h344, 32'h0000_0000);

        // CSR write masking and read-only/unmapped behaviour
        wr(12'h305, 32'h0000_0103);
        rd_chk("mtvec_mask", 12'h305, 32'h0000_0100);
        chk("mtvec_out", bus.mtvec, 32'h0000_0100);
        wr(12'h344, 32'hFFFF_FFFF);
        rd_chk("mip_ro", 12'h344, 32'h0000_0000);
        wr(12'h123, 32'hDEAD_BEEF);
        rd_chk("unmapped", 12'h123, 32'h0000_0000);
        wr(12'h341, 32'h0000_1237);
        chk("mepc_mask", bus.mepc, 32'h0000_1234);
        wr(12'h342, 32'hA5A5_5A5A);
        rd_chk("mcause_rw", 12'h342, 32'hA5A5_5A5A);
        wr(12'h304, 32'hFFFF_FFFF);
        rd_chk("mie_mask", 12'h304, 32'h000F_0000);

        // enable source 0 and global MIE, then measure pin-to-pending latency
        wr(12'h304, 32'h0001_0000);
        wr(12'h300, 32'h0000_0008);
        chk("mie_bit_set", {31'd0, bus.mie_bit}, 32'd1);
        intr_src[0] = 1'b1;
        tick();
        tick();
        tick();
        chk("lat3_low", {31'd0, bus.int_pending}, 32'd0);
        tick();
        chk("lat4_high", {31'd0, bus.int_pending}, 32'd1);

        // trap entry for source 0
        take(32'h0000_0047, 1'b0);
        chk("trap_mepc", bus.mepc, 32'h0000_0044);
        chk("trap_mie", {31'd0, bus.mie_bit}, 32'd0);
        chk("trap_pend", {31'd0, bus.int_pending}, 32'd0);
        rd_chk("trap_mcause", 12'h342, 32'h8000_0010);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_0080);
        rd_chk("held_level_once", 12'h344, 32'h0000_0000);

        // a new request during the handler must not interrupt it
        wr(12'h304, 32'h0003_0000);
        intr_src[1] = 1'b1;
        repeat (5) tick();
        chk("in_trap_pend", {31'd0, bus.int_pending}, 32'd0);
        rd_chk("in_trap_mip", 12'h344, 32'h0002_0000);
        mret();
        chk("mret_mie", {31'd0, bus.mie_bit}, 32'd1);
        chk("mret_pend", {31'd0, bus.int_pending}, 32'd1);
        rd_chk("mret_mstatus", 12'h300, 32'h0000_0088);

        // int_taken without a pending interrupt is ignored
        wr(12'h300, 32'h0000_0000);
        chk("mie_off_pend", {31'd0, bus.int_pending}, 32'd0);
        take(32'h0000_0200, 1'b0);
        chk("spur_mepc", bus.mepc, 32'h0000_0044);
        rd_chk("spur_mcause", 12'h342, 32'h8000_0010);
        rd_chk("spur_mstatus", 12'h300, 32'h0000_0000);
        wr(12'h300, 32'h0000_0008);
        chk("still_run", {31'd0, bus.int_pending}, 32'd1);

        // int_taken and mret_exec together: trap entry only
        take(32'h0000_0300, 1'b1);
        chk("both_mepc", bus.mepc, 32'h0000_0300);
        chk("both_mie", {31'd0, bus.mie_bit}, 32'd0);
        rd_chk("both_mcause", 12'h342, 32'h8000_0011);
        rd_chk("both_mstatus", 12'h300, 32'h0000_0080);
        mret();
        chk("idle_pend", {31'd0, bus.int_pending}, 32'd0);

        // arbitration between sources 0 and 2 over three rounds
        intr_src = 4'h0;
        repeat (4) tick();
        wr(12'h304, 32'h0005_0000);
        intr_src = 4'h5;
        repeat (4) tick();
        chk("arb_pend", {31'd0, bus.int_pending}, 32'd1);
        rd_chk("arb_mip", 12'h344, 32'h0005_0000);
        take(32'h0000_1000, 1'b0);
        rd_chk("arb_round1", 12'h342, exp_r1);
        mret();
        chk("arb_pend2", {31'd0, bus.int_pending}, 32'd1);
        take(32'h0000_1004, 1'b0);
        rd_chk("arb_round2", 12'h342, exp_r2);
        mret();
        chk("arb_empty", {31'd0, bus.int_pending}, 32'd0);
        intr_src = 4'h0;
        repeat (4) tick();
        intr_src = 4'h5;
        repeat (4) tick();
        take(32'h0000_1008, 1'b0);
        rd_chk("arb_round3", 12'h342, exp_r3);

        // reset while inside the handler
        intr_src = 4'h0;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_mtvec", bus.mtvec, 32'h0000_0000);
        chk("mid_rst_mepc", bus.mepc, 32'h0000_0000);
        chk("mid_rst_mie", {31'd0, bus.mie_bit}, 32'd0);
        chk("mid_rst_pend", {31'd0, bus.int_pending}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        rd_chk("post_rst_mcause", 12'h342, 32'h0000_0000);
        rd_chk("post_rst_mstatus", 12'h300, 32'h0000_0000);
        wr(12'h304, 32'h0001_0000);
        wr(12'h300, 32'h0000_0008);
        intr_src[0] = 1'b1;
        repeat (4) tick();
        chk("post_rst_run", {31'd0, bus.int_pending}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csr_intr_ctrl.md
Name: csr_intr_ctrl

Overview:
Machine-mode CSR file and interrupt controller for the OTTER core. It is the other end of the control unit's interrupt interface: it synchronizes peripheral interrupt lines, latches them as pending, and raises int_pending to the CU FSM. It consumes the FSM's int_taken and the decoder's mret execution. It supplies mtvec as the trap target (pcSource 4) and mepc as the return target (pcSource 5), and serves csrrw reads and writes.

Parameters:
NUM_SRC, 4, number of external interrupt sources (1..16).
SYNC_STAGES, 2, flops in each source synchronizer (>=2).
MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
intr_src  in  NUM_SRC  asynchronous level interrupt lines; rising edge = request
csr_we  in  1  CSR write strobe (csrrw retire cycle)
csr_addr  in  12  CSR address, ir[31:20]
csr_wd  in  32  CSR write data (rs1)
csr_rd  out  32  CSR read data, combinational, pre-write value
int_taken  in  1  FSM accepts trap this cycle (1-cycle pulse)
mret_exec  in  1  mret retires this cycle (1-cycle pulse)
pc  in  32  address to resume at (saved into mepc)
int_pending  out  1  interrupt ready to be taken
mtvec  out  32  trap vector
mepc  out  32  return address
mie_bit  out  1  mstatus.MIE

Behaviour:
- Reset: all synchronizer flops, pending, mie, mepc, mcause, MIE, MPIE and in_trap = 0; mtvec = MTVEC_RST. All outputs are therefore 0, except mtvec and csr_rd (decode of csr_addr).
- Synchronizer: each intr_src bit passes through SYNC_STAGES flops, plus one edge flop. A 0->1 transition at the synchronizer output sets pending[i] exactly one cycle later. Latency from pin to int_pending is SYNC_STAGES+2 cycles. A level held high sets pending once only.
- CSR map:
  - 0x300 mstatus: bit3 = MIE, bit7 = MPIE, all other bits read 0.
  - 0x304 mie: bits [16+NUM_SRC-1:16] enable the sources; all other bits read 0.
  - 0x305 mtvec: bits [1:0] forced to 0.
  - 0x341 mepc: bits [1:0] forced to 0.
  - 0x342 mcause: read/write.
  - 0x344 mip: pending at [16+NUM_SRC-1:16]. Reads only; writes are ignored.
  - Unmapped addresses read 0 and ignore writes.
- in_trap FSM with two states, RUN and TRAP:
  - RUN->TRAP on int_taken while int_pending=1.
  - TRAP->RUN on mret_exec.
  - int_taken while int_pending=0 is ignored and changes no state.
- int_pending = (state==RUN) & MIE & |(pending & mie_en). Registered inputs only; there is no combinational path from int_taken.
- Trap entry, on the int_taken clock edge:
  - mepc <= {pc[31:2],2'b00}.
  - mcause <= 32'h8000_0000 | (16+sel).
  - pending[sel] cleared.
  - MPIE <= MIE; MIE <= 0.
  - sel is the arbitration winner; without the optional feature, sel is the lowest enabled pending index.
- mret_exec: MIE <= MPIE; MPIE <= 1. In RUN state, mret_exec still performs the MIE/MPIE update.
- Simultaneous events:
  - int_taken and mret_exec together: int_taken wins; mret is ignored.
  - int_taken and a csr_we to mstatus, mepc or mcause: the trap update wins for those fields.
  - A new edge on sel in the same cycle as its clear: set wins, so pending stays 1.
- Reset asserted mid-handler: returns immediately to RUN with all state at reset values.

Optional Feature:
- Macro: INTR_RR_EN.
- Defined: round-robin arbitration. A last-winner pointer (reset 0) is kept; the search starts at (last+1) mod NUM_SRC and wraps. The pointer updates to sel on each accepted trap.
- Undefined: fixed priority, lowest index wins; no pointer register exists.

Test Plan:
- Reset then read each CSR → mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, mip=0, int_pending=0.
- Write mtvec=0x0000_0103 → read returns 0x0000_0100. Write mip=0xFFFF_FFFF → read returns 0.
- Write mie=0x0001_0000 and mstatus=0x8, then pulse intr_src[0] → int_pending high after 4 cycles. int_taken with pc=0x0000_0044 → mepc=0x44, mcause=0x8000_0010, MIE=0, MPIE=1, int_pending=0.
- In TRAP, raise intr_src[1] with mie=0x0003_0000 → int_pending stays 0. mret_exec → MIE=1 and int_pending rises next cycle with source 1.
- Pulse int_taken with int_pending=0 → mepc, mcause and MIE unchanged. Assert int_taken and mret_exec together → trap entry only.
- Sources 0 and 2 both pending, with three successive trap/mret rounds:
  - Fixed priority: mcause sequence 0x10, then 0x12.
  - INTR_RR_EN: after a prior win by 0, source 2 wins first.
